// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider with registered divided clock, CE pulses and divided-domain reset.
// Latency: outputs are registered and aligned with the channel counter; a loaded divisor applies at the next period wrap.
// No backpressure: load strobes are always accepted; a newer load overwrites a still-pending one.
module clock_divider_multi #(
    parameter int par_channels    = 2,
    parameter int par_div_width   = 16,
    parameter int par_div_default = 1000
) (
    input  logic                     i_clk_mhz,
    input  logic                     i_rst_mhz,
    input  logic [par_channels-1:0]  i_ch_en,
    input  logic [par_div_width-1:0] i_div_value,
    input  logic [par_channels-1:0]  i_div_load,
    output logic [par_channels-1:0]  o_div_pend,
    output logic [par_channels-1:0]  o_clk_div,
    output logic [par_channels-1:0]  o_ce_rise,
    output logic [par_channels-1:0]  o_ce_fall,
    output logic [par_channels-1:0]  o_rst_div
);

    localparam logic [par_div_width-1:0] DIV_DEFAULT = par_div_width'(par_div_default);
    localparam logic [par_div_width-1:0] ONE         = par_div_width'(1);
    localparam logic [par_div_width-1:0] TWO         = par_div_width'(2);
    localparam logic [par_div_width-1:0] ZERO        = '0;

    // Divisors 0 and 1 cannot produce a clock; clamp them once, shared by all channels.
    logic [par_div_width-1:0] load_val;
    assign load_val = (i_div_value < TWO) ? TWO : i_div_value;

    for (genvar g = 0; g < par_channels; g++) begin : g_ch
        logic [par_div_width-1:0] cnt;
        logic [par_div_width-1:0] act_d;
        logic [par_div_width-1:0] shad;
        logic [par_div_width-1:0] cnt_next;
        logic [par_div_width-1:0] d_next;
        logic [par_div_width-1:0] low_len;
        logic                     en;
        logic                     wrap;
        logic                     apply;
        logic                     pend_q;
        logic                     clk_q;
        logic                     rise_q;
        logic                     fall_q;
        logic                     rstd_q;

        assign en = i_ch_en[g];

        // Next-state decode: wrap at D-1, apply shadow at a period boundary (wrap or idle), low length of the next period.
        always_comb begin
            wrap     = en && (cnt >= act_d - ONE);
            apply    = pend_q && (wrap || !en);
            cnt_next = (!en || wrap) ? ZERO : cnt + ONE;
            d_next   = apply ? shad : act_d;
            low_len  = d_next - (d_next >> 1);
        end

        // Counter, divisor shadow and all registered outputs; outputs are computed from next state so they align with cnt.
        always_ff @(posedge i_clk_mhz) begin
            if (i_rst_mhz) begin
                cnt    <= ZERO;
                act_d  <= DIV_DEFAULT;
                shad   <= DIV_DEFAULT;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                rstd_q <= 1'b1;
            end else begin
                cnt    <= cnt_next;
                act_d  <= d_next;
                if (i_div_load[g]) begin
                    shad <= load_val;
                end
                // A load in the apply cycle is kept pending for the following boundary.
                pend_q <= i_div_load[g] ? 1'b1 : (apply ? 1'b0 : pend_q);
                clk_q  <= en && (cnt_next >= low_len);
                rise_q <= en && (cnt_next == low_len);
                fall_q <= wrap;
                rstd_q <= rstd_q && !wrap;
            end
        end

        assign o_div_pend[g] = pend_q;
        assign o_clk_div[g]  = clk_q;
        assign o_ce_rise[g]  = rise_q;
        assign o_ce_fall[g]  = fall_q;
        assign o_rst_div[g]  = rstd_q;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: directed scenarios plus randomized traffic.
// Expected outputs come from a per-channel period model evaluated with integer arithmetic.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_clock_divider_multi;

    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int DEF = 4;
    localparam int MAXD = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_en;
    logic [W-1:0]   div_value;
    logic [NCH-1:0] div_load;
    logic [NCH-1:0] div_pend;
    logic [NCH-1:0] clk_div;
    logic [NCH-1:0] ce_rise;
    logic [NCH-1:0] ce_fall;
    logic [NCH-1:0] rst_div;

    int n_tests = 0;
    int n_fail  = 0;

    clock_divider_multi #(
        .par_channels   (NCH),
        .par_div_width  (W),
        .par_div_default(DEF)
    ) dut (
        .i_clk_mhz  (clk),
        .i_rst_mhz  (rst),
        .i_ch_en    (ch_en),
        .i_div_value(div_value),
        .i_div_load (div_load),
        .o_div_pend (div_pend),
        .o_clk_div  (clk_div),
        .o_ce_rise  (ce_rise),
        .o_ce_fall  (ce_fall),
        .o_rst_div  (rst_div)
    );

    always #5 clk = ~clk;

    // Reference model: position within the current period and the divisor that governs it.
    int m_pos  [NCH];
    int m_d    [NCH];
    int m_shad [NCH];
    bit m_pend [NCH];
    bit m_clk  [NCH];
    bit m_rise [NCH];
    bit m_fall [NCH];
    bit m_rstd [NCH];

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_pos[i] = 0; m_d[i] = DEF; m_shad[i] = DEF; m_pend[i] = 0;
            m_clk[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_rstd[i] = 1;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            bit end_of_period;
            int low;
            if (rst) begin
                m_pos[i] = 0; m_d[i] = DEF; m_shad[i] = DEF; m_pend[i] = 0;
                m_clk[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_rstd[i] = 1;
            end else begin
                end_of_period = ch_en[i] && (m_pos[i] == m_d[i] - 1);
                m_fall[i] = end_of_period;
                if (end_of_period) m_rstd[i] = 0;
                m_pos[i] = (ch_en[i] && !end_of_period) ? m_pos[i] + 1 : 0;
                if (m_pend[i] && (end_of_period || !ch_en[i])) begin
                    m_d[i]    = m_shad[i];
                    m_pend[i] = 0;
                end
                if (div_load[i]) begin
                    m_shad[i] = (int'(div_value) < 2) ? 2 : int'(div_value);
                    m_pend[i] = 1;
                end
                // Low phase is the ceiling half of the period.
                low = (m_d[i] + 1) / 2;
                m_clk[i]  = ch_en[i] && (m_pos[i] >= low);
                m_rise[i] = ch_en[i] && (m_pos[i] == low);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("ch%0d_pend", i), 32'(div_pend[i]), 32'(m_pend[i]));
            chk($sformatf("ch%0d_clk",  i), 32'(clk_div[i]),  32'(m_clk[i]));
            chk($sformatf("ch%0d_rise", i), 32'(ce_rise[i]),  32'(m_rise[i]));
            chk($sformatf("ch%0d_fall", i), 32'(ce_fall[i]),  32'(m_fall[i]));
            chk($sformatf("ch%0d_rstd", i), 32'(rst_div[i]),  32'(m_rstd[i]));
        end
    endtask

    // One clock: inputs set before the call are sampled at the posedge, outputs checked at the following negedge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
    endtask

    task automatic load(input logic [NCH-1:0] mask, input int val);
        div_value = W'(val);
        div_load  = mask;
        cyc();
        div_load  = '0;
    endtask

    initial begin
        int waited;
        int period;
        rst = 1'b1; ch_en = '0; div_value = '0; div_load = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("reset_pend", 32'(div_pend), 32'h0);
        chk("reset_clk",  32'(clk_div),  32'h0);
        chk("reset_rise", 32'(ce_rise),  32'h0);
        chk("reset_fall", 32'(ce_fall),  32'h0);
        chk("reset_rstd", 32'(rst_div),  32'h3);

        // D=4 from reset: 0,0,1,1; rise on edge 2, fall and reset release on edge 4
        rst = 1'b0; ch_en = 2'b11;
        cyc(); chk("t1_edge1_clk", 32'(clk_div), 32'h0);
        cyc(); chk("t1_edge2_clk", 32'(clk_div), 32'h3);
               chk("t1_edge2_rise", 32'(ce_rise), 32'h3);
        cyc(); chk("t1_edge3_clk", 32'(clk_div), 32'h3);
               chk("t1_edge3_rstd", 32'(rst_div), 32'h3);
        cyc(); chk("t1_edge4_fall", 32'(ce_fall), 32'h3);
               chk("t1_edge4_rstd", 32'(rst_div), 32'h0);
               chk("t1_edge4_clk",  32'(clk_div), 32'h0);
        repeat (5) cyc();

        // Mid-period load of 5 on ch0 only
        load(2'b01, 5);
        chk("t2_pend_set", 32'(div_pend), 32'h1);
        repeat (20) cyc();

        // Load 0 then 7 before the wrap, then a lone load of 1 on ch1
        load(2'b01, 0);
        load(2'b01, 7);
        repeat (20) cyc();
        load(2'b10, 1);
        repeat (12) cyc();

        // Disable ch0 during its high phase for 10 cycles
        waited = 0;
        while (!clk_div[0] && waited < 50) begin cyc(); waited++; end
        chk("t4_found_high", 32'(clk_div[0]), 32'h1);
        ch_en = 2'b10;
        cyc(); chk("t4_clk_dropped", 32'(clk_div[0]), 32'h0);
        repeat (9) cyc();
        ch_en = 2'b11;
        repeat (20) cyc();

        // Reset in the same cycle as a load
        rst = 1'b1; div_value = W'(9); div_load = 2'b11;
        cyc();
        chk("t5_rstd", 32'(rst_div), 32'h3);
        chk("t5_clk",  32'(clk_div), 32'h0);
        rst = 1'b0; div_load = '0;
        cyc(); chk("t5_no_pend", 32'(div_pend), 32'h0);
        repeat (12) cyc();

        // Maximum divisor: measure one full period between ce_fall pulses on ch1
        load(2'b11, MAXD);
        waited = 0;
        while (div_pend[1] && waited < 20) begin cyc(); waited++; end
        chk("t6_applied", 32'(div_pend[1]), 32'h0);
        period = 0;
        do begin cyc(); period++; end while (!ce_fall[1] && period < 2 * MAXD);
        chk("t6_period", 32'(period), 32'(MAXD));

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 599) == 0);
            div_value = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 11));
            for (int i = 0; i < NCH; i++) begin
                div_load[i] = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 39) == 0) ch_en[i] = ~ch_en[i];
                else if (!ch_en[i] && $urandom_range(0, 3) == 0) ch_en[i] = 1'b1;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
